// File: rtl/uart_rx_capture.sv
// UART RX interrupt service engine: reads status then data, stores accepted bytes to a byte RAM.
// Optional parity/framing rejection is enabled by defining UART_CAP_PAR_CHECK_EN.
//
// state   | meaning
// IDLE    | waiting for INTERRUPT
// RD_STAT | UART status selected, captured into stat_q
// RD_DATA | UART data selected, captured into mem_wdata
// WRITE   | RAM write if byte accepted; counters/flags updated
// ACK     | INT_ACK pulse
// WAIT_LO | waiting for INTERRUPT to drop
module uart_rx_capture #(
    parameter int          ADDR_W   = 8,
    parameter bit          WRAP_EN  = 1'b0,
    parameter logic [2:0]  DATA_SEL = 3'd0,
    parameter logic [2:0]  STAT_SEL = 3'd1,
    parameter logic [2:0]  IDLE_SEL = 3'd7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              INTERRUPT,
    input  logic [7:0]        IN_PORT,
    output logic [2:0]        READ,
    output logic              INT_ACK,
    input  logic              clear,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic [7:0]        err_cnt,
    output logic              overrun
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_STAT = 3'd1,
        RD_DATA = 3'd2,
        WRITE   = 3'd3,
        ACK     = 3'd4,
        WAIT_LO = 3'd5
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] stat_q;
    logic       in_write;
    logic       byte_err;
    logic       accept;
    logic       dropped_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        READ      = IDLE_SEL;
        INT_ACK   = 1'b0;
        in_write  = 1'b0;
        case (state)
            IDLE:    if (INTERRUPT) state_nxt = RD_STAT;
            RD_STAT: begin
                READ      = STAT_SEL;
                state_nxt = RD_DATA;
            end
            RD_DATA: begin
                READ      = DATA_SEL;
                state_nxt = WRITE;
            end
            WRITE: begin
                in_write  = 1'b1;
                state_nxt = ACK;
            end
            ACK: begin
                INT_ACK   = 1'b1;
                state_nxt = WAIT_LO;
            end
            WAIT_LO: if (!INTERRUPT) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef UART_CAP_PAR_CHECK_EN
    assign byte_err = stat_q[1] | stat_q[2];
`else
    logic unused_stat;
    assign byte_err    = 1'b0;
    assign unused_stat = ^stat_q[2:1];
`endif

    assign full         = (count == DEPTH);
    assign accept       = stat_q[0] && !byte_err && (!full || WRAP_EN);
    assign dropped_full = stat_q[0] && !byte_err && full && !WRAP_EN;
    // clear wins over a coincident write so the RAM and counters agree afterwards
    assign mem_we       = in_write && accept && !clear;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_q    <= '0;
            mem_wdata <= '0;
            mem_addr  <= '0;
            count     <= '0;
            overrun   <= 1'b0;
        end else begin
            if (state == RD_STAT) stat_q    <= IN_PORT[3:0];
            if (state == RD_DATA) mem_wdata <= IN_PORT;
            if (clear) begin
                mem_addr <= '0;
                count    <= '0;
                overrun  <= 1'b0;
            end else if (in_write) begin
                if (accept) begin
                    mem_addr <= mem_addr + ADDR_W'(1);
                    if (!full) count <= count + (ADDR_W+1)'(1);
                end
                if (stat_q[3] || dropped_full) overrun <= 1'b1;
            end
        end
    end

`ifdef UART_CAP_PAR_CHECK_EN
    logic [7:0] err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= '0;
        end else if (clear) begin
            err_q <= '0;
        end else if (in_write && stat_q[0] && byte_err && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign err_cnt = err_q;
`else
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_uart_rx_capture.sv
// Directed bench for uart_rx_capture: two 4-byte instances, one dropping and one wrapping when full.
module tb_uart_rx_capture;

`ifdef UART_CAP_PAR_CHECK_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       intr = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] stat_v = 8'h00;
    logic [7:0] data_v = 8'h00;

    logic [2:0] rd_a, rd_b;
    logic [7:0] in_a, in_b;
    logic       ack_a, ack_b, we_a, we_b, full_a, full_b, ovr_a, ovr_b;
    logic [1:0] addr_a, addr_b;
    logic [7:0] wd_a, wd_b, err_a, err_b;
    logic [2:0] cnt_a, cnt_b;

    int n_chk = 0;
    int n_pass = 0;
    int wr_a = 0;
    int wr_b = 0;
    logic [1:0] m_addr_a = '0, m_addr_b = '0;
    logic [2:0] m_cnt_a = '0, m_cnt_b = '0;

    always #5 clk = ~clk;

    assign in_a = (rd_a == 3'd1) ? stat_v : (rd_a == 3'd0) ? data_v : 8'h00;
    assign in_b = (rd_b == 3'd1) ? stat_v : (rd_b == 3'd0) ? data_v : 8'h00;

    uart_rx_capture #(.ADDR_W(2), .WRAP_EN(1'b0)) dut_a (
        .clk(clk), .reset(reset), .INTERRUPT(intr), .IN_PORT(in_a), .READ(rd_a),
        .INT_ACK(ack_a), .clear(clear), .mem_we(we_a), .mem_addr(addr_a),
        .mem_wdata(wd_a), .count(cnt_a), .full(full_a), .err_cnt(err_a), .overrun(ovr_a));

    uart_rx_capture #(.ADDR_W(2), .WRAP_EN(1'b1)) dut_b (
        .clk(clk), .reset(reset), .INTERRUPT(intr), .IN_PORT(in_b), .READ(rd_b),
        .INT_ACK(ack_b), .clear(clear), .mem_we(we_b), .mem_addr(addr_b),
        .mem_wdata(wd_b), .count(cnt_b), .full(full_b), .err_cnt(err_b), .overrun(ovr_b));

    always @(posedge clk) begin
        if (we_a) wr_a++;
        if (we_b) wr_b++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // One serviced byte; starts and ends on a falling edge with the FSM idle.
    task automatic do_byte(input logic [7:0] st, input logic [7:0] d, input logic ew_a,
                           input logic ew_b, input int hold, input logic clr_wr);
        int wa, wb;
        stat_v = st;
        data_v = d;
        intr   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("read_stat", rd_a, 3'd1);
        @(negedge clk);
        check("read_data", rd_a, 3'd0);
        @(negedge clk);
        if (clr_wr) clear = 1'b1;
        #1;
        check("we_a", we_a, ew_a);
        check("we_b", we_b, ew_b);
        check("wdata_a", wd_a, d);
        if (ew_a) check("addr_a", addr_a, m_addr_a);
        if (ew_b) check("addr_b", addr_b, m_addr_b);
        @(negedge clk);
        clear = 1'b0;
        check("ack_a", ack_a, 1'b1);
        check("ack_b", ack_b, 1'b1);
        if (clr_wr) begin
            m_addr_a = '0; m_cnt_a = '0; m_addr_b = '0; m_cnt_b = '0;
        end else begin
            if (ew_a) begin m_addr_a++; if (m_cnt_a != 3'd4) m_cnt_a++; end
            if (ew_b) begin m_addr_b++; if (m_cnt_b != 3'd4) m_cnt_b++; end
        end
        check("cnt_a", cnt_a, m_cnt_a);
        check("cnt_b", cnt_b, m_cnt_b);
        check("mod_addr_a", addr_a, m_addr_a);
        check("mod_addr_b", addr_b, m_addr_b);
        wa = wr_a;
        wb = wr_b;
        for (int i = 0; i < hold; i++) @(negedge clk);
        if (hold > 0) begin
            check("hold_read", rd_a, 3'd7);
            check("hold_wr_a", wr_a, wa);
            check("hold_wr_b", wr_b, wb);
        end
        intr = 1'b0;
        @(negedge clk);
        check("ack_pulse", ack_a, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        int wa, wb;
        // 1: reset values
        repeat (2) @(negedge clk);
        check("rst_read", rd_a, 3'd7);
        check("rst_ack", ack_a, 1'b0);
        check("rst_we", we_a, 1'b0);
        check("rst_addr", addr_a, 2'd0);
        check("rst_wdata", wd_a, 8'h00);
        check("rst_cnt", cnt_a, 3'd0);
        check("rst_full", full_a, 1'b0);
        check("rst_err", err_a, 8'd0);
        check("rst_ovr", ovr_a, 1'b0);
        check("rst_read_b", rd_b, 3'd7);
        reset = 1'b1;
        @(negedge clk);

        // 2: clean byte
        do_byte(8'h01, 8'h93, 1'b1, 1'b1, 0, 1'b0);
        check("t2_cnt", cnt_a, 3'd1);

        // 3: parity error byte
        do_byte(8'h03, 8'h92, !PAR, !PAR, 0, 1'b0);
        check("t3_err_a", err_a, PAR ? 8'd1 : 8'd0);
        check("t3_err_b", err_b, PAR ? 8'd1 : 8'd0);

        // 4: fill to depth, then one more
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        m_addr_a = '0; m_cnt_a = '0; m_addr_b = '0; m_cnt_b = '0;
        check("clr_cnt", cnt_a, 3'd0);
        check("clr_err", err_a, 8'd0);
        for (int i = 0; i < 4; i++) do_byte(8'h01, 8'h10 + 8'(i), 1'b1, 1'b1, 0, 1'b0);
        check("t4_full_a", full_a, 1'b1);
        check("t4_full_b", full_b, 1'b1);
        check("t4_ovr_pre", ovr_a, 1'b0);
        do_byte(8'h01, 8'h14, 1'b0, 1'b1, 0, 1'b0);
        check("t4_cnt_a", cnt_a, 3'd4);
        check("t4_ovr_a", ovr_a, 1'b1);
        check("t4_cnt_b", cnt_b, 3'd4);
        check("t4_addr_b", addr_b, 2'd1);
        check("t4_ovr_b", ovr_b, 1'b0);

        // 5: interrupt held after ack
        wb = wr_b;
        do_byte(8'h01, 8'h21, 1'b0, 1'b1, 10, 1'b0);
        check("t5_one_wr", wr_b, wb + 1);
        do_byte(8'h01, 8'h22, 1'b0, 1'b1, 0, 1'b0);
        check("t5_next_wr", wr_b, wb + 2);

        // 6a: clear coincident with WRITE
        do_byte(8'h01, 8'h31, 1'b0, 1'b0, 0, 1'b1);
        check("t6_full", full_a, 1'b0);
        check("t6_ovr", ovr_a, 1'b0);

        // 6b: reset dropped in RD_DATA, interrupt still pending
        wa = wr_a;
        wb = wr_b;
        stat_v = 8'h01;
        data_v = 8'h5A;
        intr   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        check("t6_rd_data", rd_a, 3'd0);
        reset = 1'b0;
        #1;
        check("t6_rst_read", rd_a, 3'd7);
        check("t6_rst_we", we_a, 1'b0);
        @(negedge clk);
        check("t6_no_wr_a", wr_a, wa);
        check("t6_no_wr_b", wr_b, wb);
        reset = 1'b1;
        m_addr_a = '0; m_cnt_a = '0; m_addr_b = '0; m_cnt_b = '0;
        do_byte(8'h01, 8'h5A, 1'b1, 1'b1, 0, 1'b0);

        // UART-reported overrun on an otherwise good byte
        do_byte(8'h09, 8'h77, 1'b1, 1'b1, 0, 1'b0);
        check("ovr_stat_a", ovr_a, 1'b1);
        check("ovr_stat_b", ovr_b, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
